// File: rtl/nic_pkg.sv
// nic_pkg: shared ring definitions used by the NIC fabric and the global
// memory gateway: packet layout, packet type codes, node ids, the gateway
// bus FSM states and small packet helpers.
package nic_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Packet type codes
  localparam logic [3:0] PT_NULL  = 4'd0;
  localparam logic [3:0] PT_READ  = 4'd1;
  localparam logic [3:0] PT_WRITE = 4'd2;
  localparam logic [3:0] PT_AREAD = 4'd3;
  localparam logic [3:0] PT_ACK   = 4'd4;
  localparam logic [3:0] PT_AACK  = 4'd5;
  localparam logic [3:0] PT_ERR   = 4'd6;
  localparam logic [3:0] PT_VPA   = 4'd7;
  localparam logic [3:0] PT_IRQ   = 4'd8;

  // Node used by every NIC for global DRAM/ROM/IO, and the broadcast id
  localparam logic [5:0] NIC_GBL_ID   = 6'd62;
  localparam logic [5:0] NIC_BCAST_ID = 6'd63;

  typedef struct packed {
    logic [5:0]  sid;
    logic [5:0]  did;
    logic [3:0]  age;
    logic        ack;
    logic [3:0]  typ;
    logic [7:0]  asid;
    logic        mmus;
    logic        ios;
    logic        iops;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } gw_state_t;

  // Packet types that the gateway services
  function automatic logic is_req(input logic [3:0] typ);
    return (typ == PT_READ) || (typ == PT_AREAD) || (typ == PT_WRITE);
  endfunction

  // A ring slot carries nothing when both node ids are zero
  function automatic logic slot_empty(input packet_t p);
    return (p.sid | p.did) == 6'd0;
  endfunction

endpackage

// File: rtl/nic_pkt_fifo.sv
// nic_pkt_fifo: request queue of packets for the memory gateway.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_data write
// side; i_pop read side with o_data showing the head entry; o_full, o_empty
// and o_count report occupancy. The owner never pushes when full nor pops
// when empty; push and pop together keep the occupancy constant.
module nic_pkt_fifo
  import nic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  packet_t                    i_data,
  output packet_t                    o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  packet_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Storage array, written at the tail
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_count = r_count;

endmodule

// File: rtl/nic_mem_gateway.sv
// nic_mem_gateway: ring responder for the global memory/IO region.
// Ports: clk_i/rst_ni clock and async active-low reset; packet_i/packet_o the
// request ring (one-cycle pass-through, requests to NODE_ID removed);
// rpacket_i/rpacket_o the response ring (responses injected into empty
// slots); m_* a single-master memory bus; busy_o high while a bus cycle runs
// or a response waits; q_count_o the request queue occupancy.
module nic_mem_gateway
  import nic_pkg::*;
#(
  parameter logic [5:0] NODE_ID = NIC_GBL_ID,
  parameter int         QDEPTH  = 4,
  parameter int         TIMEOUT = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  packet_t                     packet_i,
  output packet_t                     packet_o,
  input  packet_t                     rpacket_i,
  output packet_t                     rpacket_o,
  output logic                        m_cyc_o,
  output logic                        m_stb_o,
  output logic                        m_we_o,
  output logic [3:0]                  m_sel_o,
  output logic [7:0]                  m_asid_o,
  output logic [31:0]                 m_adr_o,
  output logic [31:0]                 m_dat_o,
  output logic                        m_mmus_o,
  output logic                        m_ios_o,
  output logic                        m_iops_o,
  input  logic                        m_ack_i,
  input  logic                        m_err_i,
  input  logic                        m_vpa_i,
  input  logic [31:0]                 m_dat_i,
  output logic                        busy_o,
  output logic [$clog2(QDEPTH+1)-1:0] q_count_o
);

  localparam int TW = $clog2(TIMEOUT+1);

  gw_state_t     r_state;
  gw_state_t     w_state_nxt;
  packet_t       r_req;
  packet_t       r_rsp;
  logic          r_rsp_vld;
  logic [TW-1:0] r_tmo;

  packet_t       w_head;
  packet_t       w_rsp;
  logic          w_full;
  logic          w_empty;
  logic          w_hit;
  logic          w_req;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_term;
  logic          w_load;

  nic_pkt_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (packet_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (q_count_o)
  );

  // Capture decision; a full queue lets requests recirculate instead of dropping them
  always_comb begin
    w_hit  = (packet_i.did == NODE_ID) && (packet_i.did != NIC_BCAST_ID);
    w_req  = is_req(packet_i.typ);
    w_push = w_hit && w_req && !w_full;
    w_drop = w_hit && !w_req;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pop)  w_state_nxt = ST_BUS;  else w_state_nxt = ST_IDLE;
      ST_BUS:  if (w_term) w_state_nxt = ST_IDLE; else w_state_nxt = ST_BUS;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: pop/terminate strobes and the response built from the request
  always_comb begin
    w_pop  = FALSE;
    w_term = FALSE;
    w_load = FALSE;
    // Start from the request so asid/space qualifiers/address carry over
    w_rsp      = r_req;
    w_rsp.sid  = NODE_ID;
    w_rsp.did  = r_req.sid;
    w_rsp.age  = 4'd0;
    w_rsp.ack  = TRUE;
    w_rsp.sel  = 4'h0;
    w_rsp.dat  = 32'h0;
    if (m_ack_i) begin
      w_rsp.typ = (r_req.typ == PT_AREAD) ? PT_AACK : PT_ACK;
      w_rsp.dat = m_dat_i;
    end else if (m_err_i) begin
      w_rsp.typ = PT_ERR;
    end else if (m_vpa_i) begin
      w_rsp.typ = PT_VPA;
    end else begin
      w_rsp.typ = PT_ERR;
    end
    case (r_state)
      ST_IDLE: begin
        // Holding a response blocks new work so load and inject never collide
        w_pop = !w_empty && !r_rsp_vld;
      end
      ST_BUS: begin
        w_term = m_ack_i || m_err_i || m_vpa_i || (r_tmo == TW'(TIMEOUT));
        w_load = w_term && (r_req.typ != PT_WRITE);
      end
      default: begin
        w_pop = FALSE;
      end
    endcase
  end

  // Bus master registers and timeout counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cyc_o  <= 1'b0;
      m_stb_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_sel_o  <= 4'h0;
      m_asid_o <= 8'h0;
      m_adr_o  <= 32'h0;
      m_dat_o  <= 32'h0;
      m_mmus_o <= 1'b0;
      m_ios_o  <= 1'b0;
      m_iops_o <= 1'b0;
      r_req    <= '0;
      r_tmo    <= '0;
    end else if (w_pop) begin
      m_cyc_o  <= 1'b1;
      m_stb_o  <= 1'b1;
      m_we_o   <= (w_head.typ == PT_WRITE);
      m_sel_o  <= (w_head.typ == PT_WRITE) ? w_head.sel : 4'hF;
      m_dat_o  <= (w_head.typ == PT_WRITE) ? w_head.dat : 32'h0;
      m_asid_o <= w_head.asid;
      m_adr_o  <= w_head.adr;
      m_mmus_o <= w_head.mmus;
      m_ios_o  <= w_head.ios;
      m_iops_o <= w_head.iops;
      r_req    <= w_head;
      r_tmo    <= '0;
    end else if (w_term) begin
      m_cyc_o  <= 1'b0;
      m_stb_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_sel_o  <= 4'h0;
    end else if (r_state == ST_BUS) begin
      r_tmo    <= r_tmo + TW'(1);
    end
  end

  // Request ring pass-through; captured and foreign-typed packets leave an empty slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                packet_o <= '0;
    else if (w_push || w_drop)  packet_o <= '0;
    else                        packet_o <= packet_i;
  end

  // Response holding register and injection into the first empty response slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp     <= '0;
      r_rsp_vld <= FALSE;
      rpacket_o <= '0;
    end else if (w_load) begin
      r_rsp     <= w_rsp;
      r_rsp_vld <= TRUE;
      rpacket_o <= rpacket_i;
    end else if (r_rsp_vld && slot_empty(rpacket_i)) begin
      r_rsp_vld <= FALSE;
      rpacket_o <= r_rsp;
    end else begin
      rpacket_o <= rpacket_i;
    end
  end

  assign busy_o = (r_state != ST_IDLE) || r_rsp_vld;

endmodule
